// File: rtl/generation_sequencer.sv
// Generation sequencer for a cellular-automaton array: waits for the adder tree to settle,
// pulses a global update, then pauses for a programmable dwell. Optional macro CA_GEN_LIMIT_EN adds genTarget.
module generation_sequencer #(
  parameter int ADDER_LATENCY = 2,
  parameter int GEN_WIDTH     = 16,
  parameter int DWELL_WIDTH   = 24
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   stepMode,
  input  logic                   clearCount,
  input  logic [DWELL_WIDTH-1:0] dwell,
`ifdef CA_GEN_LIMIT_EN
  input  logic [GEN_WIDTH-1:0]   genTarget,
`endif
  output logic                   updateEn,
  output logic                   busy,
  output logic                   done,
  output logic [GEN_WIDTH-1:0]   genCount,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    UPDATE = 2'd2,
    DWELL  = 2'd3
  } state_t;

  localparam int SW = $clog2(ADDER_LATENCY + 2);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(ADDER_LATENCY);

  state_t                 state;
  logic [SW-1:0]          settle_cnt;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic                   stop_pending;
  logic                   step_q;
  logic                   limit_hit;

  // genCount already holds the incremented value while in UPDATE.
`ifdef CA_GEN_LIMIT_EN
  logic [GEN_WIDTH-1:0] target_q;
  assign limit_hit = (target_q != '0) && (genCount == target_q);
`else
  assign limit_hit = 1'b0;
`endif

  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      updateEn     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      genCount     <= '0;
      stop_pending <= 1'b0;
      step_q       <= 1'b0;
      settle_cnt   <= '0;
      dwell_cnt    <= '0;
`ifdef CA_GEN_LIMIT_EN
      target_q     <= '0;
`endif
    end else begin
      updateEn <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (clearCount) genCount <= '0;
          if (start && !stop) begin
            state        <= SETTLE;
            busy         <= 1'b1;
            step_q       <= stepMode;
            stop_pending <= 1'b0;
            settle_cnt   <= '0;
`ifdef CA_GEN_LIMIT_EN
            target_q     <= genTarget;
`endif
          end
        end
        SETTLE: begin
          if (stop) stop_pending <= 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state    <= UPDATE;
            updateEn <= 1'b1;
            genCount <= genCount + 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        UPDATE: begin
          dwell_cnt  <= dwell;
          settle_cnt <= '0;
          if (stop || stop_pending || step_q || limit_hit) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            stop_pending <= 1'b0;
            step_q       <= 1'b0;
          end else if (dwell != '0) begin
            state <= DWELL;
          end else begin
            state <= SETTLE;
          end
        end
        DWELL: begin
          if (stop || stop_pending) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            stop_pending <= 1'b0;
            step_q       <= 1'b0;
          end else if (dwell_cnt == DWELL_WIDTH'(1)) begin
            state <= SETTLE;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
